// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline boundary: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush, write-back result mux, x0 write suppression
// and a WB-stage forwarding tap for the hazard unit.
module mem_wb_skid_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RES_SRC_W  = 2,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  m_valid_i,
  output logic                  m_ready_o,
  input  logic                  m_reg_write_i,
  input  logic [RES_SRC_W-1:0]  m_result_src_i,
  input  logic [XLEN-1:0]       m_alu_result_i,
  input  logic [XLEN-1:0]       m_rdata_i,
  input  logic [REG_ADDR_W-1:0] m_rd_i,
  input  logic [XLEN-1:0]       m_pc_plus4_i,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic                  w_reg_write_o,
  output logic [REG_ADDR_W-1:0] w_rd_o,
  output logic [XLEN-1:0]       w_result_o,
  output logic                  fwd_valid_o
);

  typedef struct packed {
    logic                  reg_write;
    logic [RES_SRC_W-1:0]  result_src;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       rdata;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       pc_plus4;
  } entry_t;

  entry_t in_entry;
  entry_t main_q;
  logic   main_valid;
  logic   accept;
  logic   retire;

  assign in_entry = '{reg_write:  m_reg_write_i,
                      result_src: m_result_src_i,
                      alu_result: m_alu_result_i,
                      rdata:      m_rdata_i,
                      rd:         m_rd_i,
                      pc_plus4:   m_pc_plus4_i};

  assign accept = m_valid_i & m_ready_o;
  assign retire = main_valid & w_ready_i;

  generate
    if (SKID_EN) begin : g_skid
      entry_t skid_q;
      logic   skid_valid;

      // Ready comes straight from the skid flop, so it never depends on w_ready_i.
      assign m_ready_o = !skid_valid;

      // Main/skid occupancy: the skid only fills when main is held, and drains into main first.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          main_q     <= '0;
          skid_q     <= '0;
        end else if (flush_i) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (retire) begin
          if (skid_valid) begin
            // No accept possible here: m_ready_o is low while skid is full.
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
          end else if (accept) begin
            main_q     <= in_entry;
            main_valid <= 1'b1;
          end else begin
            main_valid <= 1'b0;
          end
        end else if (accept) begin
          if (!main_valid) begin
            main_q     <= in_entry;
            main_valid <= 1'b1;
          end else begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
          end
        end
      end
    end else begin : g_noskid
      // Single entry: room whenever main is empty or leaving this cycle.
      assign m_ready_o = !main_valid | w_ready_i;

      // Main occupancy; an accept alongside a retire replaces main in place.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_q     <= '0;
        end else if (flush_i) begin
          main_valid <= 1'b0;
        end else if (accept) begin
          main_q     <= in_entry;
          main_valid <= 1'b1;
        end else if (retire) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

  logic [XLEN-1:0] mux_result;

  // Write-back result select from the main entry; reserved select yields zero.
  always_comb begin
    mux_result = '0;
    case (main_q.result_src)
      RES_SRC_W'(0): mux_result = main_q.alu_result;
      RES_SRC_W'(1): mux_result = main_q.rdata;
      RES_SRC_W'(2): mux_result = main_q.pc_plus4;
      default:       mux_result = '0;
    endcase
  end

  // Outputs are masked by valid so stale payload after a flush never leaks out.
  assign w_valid_o     = main_valid;
  assign w_reg_write_o = main_valid & main_q.reg_write & (main_q.rd != '0);
  assign w_rd_o        = main_valid ? main_q.rd : '0;
  assign w_result_o    = main_valid ? mux_result : '0;
  assign fwd_valid_o   = w_valid_o & w_reg_write_o;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage (SKID_EN=1): streaming, backpressure,
// result mux / x0, flush and asynchronous reset mid-stall.
module tb_mem_wb_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        m_valid_i;
  logic        m_ready_o;
  logic        m_reg_write_i;
  logic [1:0]  m_result_src_i;
  logic [31:0] m_alu_result_i;
  logic [31:0] m_rdata_i;
  logic [4:0]  m_rd_i;
  logic [31:0] m_pc_plus4_i;
  logic        w_valid_o;
  logic        w_ready_i;
  logic        w_reg_write_o;
  logic [4:0]  w_rd_o;
  logic [31:0] w_result_o;
  logic        fwd_valid_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_wb_skid_stage #(.XLEN(32), .REG_ADDR_W(5), .RES_SRC_W(2), .SKID_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
    .m_reg_write_i(m_reg_write_i), .m_result_src_i(m_result_src_i),
    .m_alu_result_i(m_alu_result_i), .m_rdata_i(m_rdata_i),
    .m_rd_i(m_rd_i), .m_pc_plus4_i(m_pc_plus4_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_reg_write_o(w_reg_write_o), .w_rd_o(w_rd_o),
    .w_result_o(w_result_o), .fwd_valid_o(fwd_valid_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [4:0] rd, input logic [31:0] pc4);
    m_valid_i      = v;
    m_reg_write_i  = rw;
    m_result_src_i = src;
    m_alu_result_i = alu;
    m_rdata_i      = rdata;
    m_rd_i         = rd;
    m_pc_plus4_i   = pc4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; w_ready_i = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0);
    #12;
    n_cmp++; if (w_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_w_valid got=%b exp=0", w_valid_o); end
    n_cmp++; if (m_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_m_ready got=%b exp=1", m_ready_o); end
    n_cmp++; if (w_result_o !== 32'h0) begin n_err++; $display("FAIL reset_w_result got=%h exp=0", w_result_o); end
    n_cmp++; if (w_reg_write_o !== 1'b0 || fwd_valid_o !== 1'b0 || w_rd_o !== 5'd0) begin
      n_err++; $display("FAIL reset_wr_fwd_rd got=%b/%b/%0d exp=0/0/0", w_reg_write_o, fwd_valid_o, w_rd_o); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    w_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'd0, 32'h10 + 32'(i), 32'hFFFF_0000, 5'(i + 1), 32'h4);
      step();
      n_cmp++; if (w_valid_o !== 1'b1 || w_result_o !== 32'h10 + 32'(i)) begin
        n_err++; $display("FAIL stream_result[%0d] got=%b/%h exp=1/%h", i, w_valid_o, w_result_o, 32'h10 + 32'(i)); end
      n_cmp++; if (w_rd_o !== 5'(i + 1) || w_reg_write_o !== 1'b1) begin
        n_err++; $display("FAIL stream_rd[%0d] got=%0d/%b exp=%0d/1", i, w_rd_o, w_reg_write_o, i + 1); end
      n_cmp++; if (m_ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, m_ready_o); end
    end
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0);
    step();
    n_cmp++; if (w_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_drain got=%b exp=0", w_valid_o); end
  endtask

  task automatic test_backpressure();
    w_ready_i = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 32'hAAAA, 32'h0, 5'd6, 32'h0);
    step();
    n_cmp++; if (w_result_o !== 32'hAAAA || m_ready_o !== 1'b1) begin
      n_err++; $display("FAIL bp_A_in got=%h/%b exp=aaaa/1", w_result_o, m_ready_o); end
    drive(1'b1, 1'b1, 2'd0, 32'hBBBB, 32'h0, 5'd7, 32'h0);
    step();
    n_cmp++; if (m_ready_o !== 1'b0 || w_result_o !== 32'hAAAA) begin
      n_err++; $display("FAIL bp_B_skid got=%b/%h exp=0/aaaa", m_ready_o, w_result_o); end
    drive(1'b1, 1'b1, 2'd0, 32'hCCCC, 32'h0, 5'd8, 32'h0);
    step();
    n_cmp++; if (m_ready_o !== 1'b0 || w_result_o !== 32'hAAAA) begin
      n_err++; $display("FAIL bp_C_held got=%b/%h exp=0/aaaa", m_ready_o, w_result_o); end
    w_ready_i = 1'b1;
    step();
    n_cmp++; if (w_result_o !== 32'hBBBB || w_rd_o !== 5'd7 || m_ready_o !== 1'b1) begin
      n_err++; $display("FAIL bp_B_out got=%h/%0d/%b exp=bbbb/7/1", w_result_o, w_rd_o, m_ready_o); end
    step();
    n_cmp++; if (w_result_o !== 32'hCCCC || w_rd_o !== 5'd8) begin
      n_err++; $display("FAIL bp_C_out got=%h/%0d exp=cccc/8", w_result_o, w_rd_o); end
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0);
    step();
    n_cmp++; if (w_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got=%b exp=0", w_valid_o); end
  endtask

  task automatic test_mux_x0();
    w_ready_i = 1'b1;
    drive(1'b1, 1'b1, 2'd1, 32'h1234, 32'hDEADBEEF, 5'd5, 32'h8);
    step();
    n_cmp++; if (w_result_o !== 32'hDEADBEEF || w_reg_write_o !== 1'b1 || fwd_valid_o !== 1'b1) begin
      n_err++; $display("FAIL mux_load got=%h/%b/%b exp=deadbeef/1/1", w_result_o, w_reg_write_o, fwd_valid_o); end
    drive(1'b1, 1'b1, 2'd1, 32'h1234, 32'hDEADBEEF, 5'd0, 32'h8);
    step();
    n_cmp++; if (w_valid_o !== 1'b1 || w_reg_write_o !== 1'b0 || fwd_valid_o !== 1'b0) begin
      n_err++; $display("FAIL x0_suppress got=%b/%b/%b exp=1/0/0", w_valid_o, w_reg_write_o, fwd_valid_o); end
    drive(1'b1, 1'b1, 2'd2, 32'h1234, 32'h5678, 5'd9, 32'h80000004);
    step();
    n_cmp++; if (w_result_o !== 32'h80000004) begin n_err++; $display("FAIL mux_pc4 got=%h exp=80000004", w_result_o); end
    drive(1'b1, 1'b1, 2'd3, 32'h1234, 32'h5678, 5'd9, 32'h80000004);
    step();
    n_cmp++; if (w_result_o !== 32'h0 || w_valid_o !== 1'b1) begin
      n_err++; $display("FAIL mux_rsvd got=%h/%b exp=0/1", w_result_o, w_valid_o); end
    drive(1'b1, 1'b0, 2'd0, 32'h4321, 32'h0, 5'd10, 32'h0);
    step();
    n_cmp++; if (w_reg_write_o !== 1'b0 || w_result_o !== 32'h4321 || w_rd_o !== 5'd10) begin
      n_err++; $display("FAIL no_regwrite got=%b/%h/%0d exp=0/4321/10", w_reg_write_o, w_result_o, w_rd_o); end
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0);
    step();
  endtask

  task automatic test_flush();
    w_ready_i = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 32'h111, 32'h0, 5'd1, 32'h0);
    step();
    drive(1'b1, 1'b1, 2'd0, 32'h222, 32'h0, 5'd2, 32'h0);
    step();
    drive(1'b1, 1'b1, 2'd0, 32'h333, 32'h0, 5'd3, 32'h0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_cmp++; if (w_valid_o !== 1'b0 || m_ready_o !== 1'b1 || w_result_o !== 32'h0) begin
      n_err++; $display("FAIL flush_full got=%b/%b/%h exp=0/1/0", w_valid_o, m_ready_o, w_result_o); end
    // Flush while empty and ready: the same-cycle accept must be dropped.
    w_ready_i = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 32'h444, 32'h0, 5'd4, 32'h0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0);
    n_cmp++; if (w_valid_o !== 1'b0 || w_rd_o !== 5'd0) begin
      n_err++; $display("FAIL flush_accept got=%b/%0d exp=0/0", w_valid_o, w_rd_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (w_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_ghost[%0d] got=%b/%h exp=0", i, w_valid_o, w_result_o); end
    end
  endtask

  task automatic test_async_reset();
    w_ready_i = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 32'h77, 32'h0, 5'd11, 32'h0);
    step();
    drive(1'b1, 1'b1, 2'd0, 32'h88, 32'h0, 5'd12, 32'h0);
    step();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0);
    n_cmp++; if (w_valid_o !== 1'b1 || m_ready_o !== 1'b0) begin
      n_err++; $display("FAIL ares_pre got=%b/%b exp=1/0", w_valid_o, m_ready_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (w_valid_o !== 1'b0 || w_reg_write_o !== 1'b0 || fwd_valid_o !== 1'b0) begin
      n_err++; $display("FAIL ares_valid got=%b/%b/%b exp=0/0/0", w_valid_o, w_reg_write_o, fwd_valid_o); end
    n_cmp++; if (w_rd_o !== 5'd0 || w_result_o !== 32'h0 || m_ready_o !== 1'b1) begin
      n_err++; $display("FAIL ares_data got=%0d/%h/%b exp=0/0/1", w_rd_o, w_result_o, m_ready_o); end
    @(negedge clk); rst_n = 1'b1;
    w_ready_i = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 32'h55, 32'h0, 5'd13, 32'h0);
    step();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0);
    n_cmp++; if (w_valid_o !== 1'b1 || w_result_o !== 32'h55 || w_rd_o !== 5'd13) begin
      n_err++; $display("FAIL ares_after got=%b/%h/%0d exp=1/55/13", w_valid_o, w_result_o, w_rd_o); end
    step();
    n_cmp++; if (w_valid_o !== 1'b0) begin n_err++; $display("FAIL ares_drain got=%b exp=0", w_valid_o); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_mux_x0();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised MEM→WB pipeline boundary with a valid/ready handshake, an optional 2-entry skid buffer, and synchronous flush.
- Merges the write-back result mux into the stage, so the register file sees a final result, rd and write-enable.
- Suppresses writes to x0.
- Exports a WB-stage forwarding tap for the hazard unit.

Parameters:
- XLEN, 32, datapath width of ALU result, load data, PC+4 and result.
- REG_ADDR_W, 5, register-index width.
- RES_SRC_W, 2, width of the result-select field.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered m_ready_o; 0 = single entry with combinational ready.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all held entries.
- m_valid_i  in  1  MEM stage presents an entry.
- m_ready_o  out  1  stage can accept an entry.
- m_reg_write_i  in  1  entry writes the register file.
- m_result_src_i  in  RES_SRC_W  result select: 0 ALU, 1 load data, 2 PC+4, 3 reserved.
- m_alu_result_i  in  XLEN  ALU result.
- m_rdata_i  in  XLEN  load data.
- m_rd_i  in  REG_ADDR_W  destination register.
- m_pc_plus4_i  in  XLEN  PC+4.
- w_valid_o  out  1  WB entry valid.
- w_ready_i  in  1  WB consumer accepts the entry.
- w_reg_write_o  out  1  register-file write enable, qualified.
- w_rd_o  out  REG_ADDR_W  destination register.
- w_result_o  out  XLEN  selected write-back data.
- fwd_valid_o  out  1  forwarding tap valid (= w_valid_o & w_reg_write_o).

Behaviour:
- Handshakes:
  - Accept on m_valid_i & m_ready_o at a rising clk edge.
  - Retire on w_valid_o & w_ready_i at a rising clk edge.
- Storage:
  - Main entry drives the W outputs.
  - Skid entry is present only when SKID_EN=1.
  - Payload stored per entry: reg_write, result_src, alu_result, rdata, rd, pc_plus4.
- Result mux (combinational from the main entry):
  - src 0 → alu_result.
  - src 1 → rdata.
  - src 2 → pc_plus4.
  - src 3 → all-zero.
- Write qualification:
  - w_reg_write_o = main_valid & reg_write & (rd != 0).
  - When main is invalid: w_reg_write_o=0, w_result_o=0, w_rd_o=0.
- SKID_EN=1:
  - m_ready_o = !skid_valid, taken directly from a flop with no combinational path from w_ready_i.
  - Main empty, or retiring this cycle: an accepted entry goes to main.
  - Main full and not retiring: an accepted entry goes to skid.
  - Retire while skid is full: skid moves to main; an entry accepted in the same cycle is impossible because m_ready_o=0.
  - Ordering is strictly FIFO, with no duplication or loss.
- SKID_EN=0:
  - m_ready_o = !main_valid | w_ready_i (combinational).
  - Accept with simultaneous retire replaces main in that cycle.
  - The skid register is not instantiated.
- Latency: an accepted entry appears on W outputs one cycle later when the stage was empty or draining. Throughput is one per cycle while w_ready_i=1.
- Flush:
  - flush_i=1 at an edge clears main_valid and skid_valid.
  - Any accept in the same cycle is discarded.
  - m_ready_o=1 on the following cycle.
  - Payload flops may retain stale data; outputs are masked by valid.
- Reset (async assert, any point including mid-transfer):
  - All valid bits clear.
  - All payload flops reset to 0.
  - Outputs during and after reset: w_valid_o=0, w_reg_write_o=0, w_rd_o=0, w_result_o=0, fwd_valid_o=0, m_ready_o=1.
- Widths: all datapath fields are XLEN with no sign or zero extension inside the block. rd is compared against zero at REG_ADDR_W width.

Test Plan:
- Streaming: 4 entries back-to-back, w_ready_i=1, src 0, ALU results 0x10..0x13, rd 1..4 → W outputs show 0x10..0x13 in order, one per cycle starting 1 cycle after the first accept; m_ready_o stays 1.
- Backpressure with skid (SKID_EN=1):
  - Drop w_ready_i for 3 cycles while entries A(0xAAAA) and B(0xBBBB) arrive → m_ready_o falls to 0 the cycle after B is accepted; C is held off.
  - Raise w_ready_i → A, B, C retire in order with no loss or duplication.
- Result mux and x0: src 1 with rdata 0xDEADBEEF and rd=5 → w_result_o=0xDEADBEEF, w_reg_write_o=1. Repeat with rd=0 → w_reg_write_o=0, fwd_valid_o=0, w_valid_o=1.
- PC+4 and reserved select: src 2 with pc_plus4 0x80000004 → w_result_o=0x80000004. src 3 → w_result_o=0x00000000.
- Flush: with main and skid both full, assert flush_i for one cycle together with m_valid_i → next cycle w_valid_o=0, m_ready_o=1, and the flushed-cycle entry never appears.
- Async reset mid-stall: assert rst_n=0 between edges while w_ready_i=0 → outputs reach reset values immediately. After release, a new entry 0x55 passes through normally.
